// File: rtl/led_pattern_sequencer.sv
// Plays LED blink patterns one bit per PRESCALE-cycle slot, with one active
// pattern, a one-entry pending buffer, looped/one-shot playback and abort.
module led_pattern_sequencer #(
  parameter int PAT_W    = 32,
  parameter int PRESCALE = 1048576,
  parameter int LEN_W    = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [PAT_W-1:0] PAT_DATA,
  input  logic [LEN_W-1:0] PAT_LEN,
  input  logic             PAT_LOOP,
  input  logic             PAT_VALID,
  output logic             PAT_READY,
  input  logic             ABORT,
  output logic             LED,
  output logic             BUSY,
  output logic             DONE
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_MAX   = PS_W'(PRESCALE - 1);
  localparam logic [LEN_W-1:0] MAX_LAST = LEN_W'(PAT_W - 1);
  localparam logic [LEN_W:0]   PAT_W_X  = (LEN_W + 1)'(PAT_W);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t             state, state_n;
  logic [PAT_W-1:0]   act_data, act_data_n, pend_data, pend_data_n;
  logic [LEN_W-1:0]   act_last, act_last_n, pend_last, pend_last_n;
  logic               act_loop, act_loop_n, pend_loop, pend_loop_n;
  logic               pend_full, pend_full_n;
  logic [PS_W-1:0]    presc, presc_n;
  logic [LEN_W-1:0]   bit_idx, bit_idx_n;
  logic               led_n, busy_n, done_n;
  logic [PAT_W-1:0]   led_shift;
  logic [LEN_W-1:0]   cap_last;
  logic               xfer, wrap, end_pat;

  // Handshake: a pattern transfers on any posedge where PAT_VALID && PAT_READY;
  // upstream holds PAT_DATA/PAT_LEN/PAT_LOOP stable while PAT_VALID && !PAT_READY.
  assign PAT_READY = RST_N && !ABORT && !pend_full;
  assign xfer      = PAT_VALID && PAT_READY;

  // Store the index of the last bit so PAT_W=2^LEN_W still fits in LEN_W bits.
  assign cap_last = ((PAT_LEN == '0) || ({1'b0, PAT_LEN} > PAT_W_X))
                    ? MAX_LAST : (PAT_LEN - LEN_W'(1));

  assign wrap    = (presc == PS_MAX);
  assign end_pat = wrap && (bit_idx == act_last);

  always_comb begin
    state_n     = state;
    act_data_n  = act_data;
    act_last_n  = act_last;
    act_loop_n  = act_loop;
    pend_full_n = pend_full;
    pend_data_n = pend_data;
    pend_last_n = pend_last;
    pend_loop_n = pend_loop;
    presc_n     = presc;
    bit_idx_n   = bit_idx;
    done_n      = 1'b0;

    if (ABORT) begin
      state_n     = IDLE;
      pend_full_n = 1'b0;
      presc_n     = '0;
      bit_idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state_n    = PLAY;
            act_data_n = PAT_DATA;
            act_last_n = cap_last;
            act_loop_n = PAT_LOOP;
            presc_n    = '0;
            bit_idx_n  = '0;
          end
        end
        PLAY: begin
          if (!wrap) begin
            presc_n = presc + PS_W'(1);
          end else begin
            presc_n = '0;
            if (bit_idx != act_last) begin
              bit_idx_n = bit_idx + LEN_W'(1);
            end else begin
              bit_idx_n = '0;
              if (pend_full) begin
                act_data_n  = pend_data;
                act_last_n  = pend_last;
                act_loop_n  = pend_loop;
                pend_full_n = 1'b0;
              end else if (xfer) begin
                act_data_n = PAT_DATA;
                act_last_n = cap_last;
                act_loop_n = PAT_LOOP;
              end else if (!act_loop) begin
                state_n = IDLE;
                done_n  = 1'b1;
              end
            end
          end
          // Mid-pattern offers wait in pending until the current pass ends.
          if (xfer && !end_pat) begin
            pend_full_n = 1'b1;
            pend_data_n = PAT_DATA;
            pend_last_n = cap_last;
            pend_loop_n = PAT_LOOP;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    led_shift = act_data_n >> bit_idx_n;
    busy_n    = (state_n == PLAY);
    led_n     = busy_n && led_shift[0];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      act_data  <= '0;
      act_last  <= '0;
      act_loop  <= 1'b0;
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_last <= '0;
      pend_loop <= 1'b0;
      presc     <= '0;
      bit_idx   <= '0;
      LED       <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      act_data  <= act_data_n;
      act_last  <= act_last_n;
      act_loop  <= act_loop_n;
      pend_full <= pend_full_n;
      pend_data <= pend_data_n;
      pend_last <= pend_last_n;
      pend_loop <= pend_loop_n;
      presc     <= presc_n;
      bit_idx   <= bit_idx_n;
      LED       <= led_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with PRESCALE=4: playback timing,
// pending buffer, looping, abort, reset and length clamping.
module tb_led_pattern_sequencer;

  logic        clk;
  logic        rst_n;
  logic [31:0] pat_data;
  logic [5:0]  pat_len;
  logic        pat_loop;
  logic        pat_valid;
  logic        pat_ready;
  logic        abort;
  logic        led;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  led_pattern_sequencer #(.PAT_W(32), .PRESCALE(4), .LEN_W(6)) dut (
    .CLK(clk), .RST_N(rst_n), .PAT_DATA(pat_data), .PAT_LEN(pat_len),
    .PAT_LOOP(pat_loop), .PAT_VALID(pat_valid), .PAT_READY(pat_ready),
    .ABORT(abort), .LED(led), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a pattern and return #1 after the edge where it transferred.
  task automatic send(input logic [31:0] d, input logic [5:0] l, input logic lp);
    pat_data  = d;
    pat_len   = l;
    pat_loop  = lp;
    pat_valid = 1'b1;
    for (int i = 0; i < 50 && !pat_ready; i++) tick();
    checks++;
    if (pat_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout ready=%b want 1", pat_ready);
    end
    tick();
    pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", led); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", pat_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (pat_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b want 1", pat_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b want 0", busy); end
  endtask

  task automatic test_one_shot();
    logic exp_bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    send(32'h0000000D, 6'd4, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++; if (led !== exp_bits[k/4]) begin errors++; $display("FAIL oneshot_led k=%0d got %b want %b", k, led, exp_bits[k/4]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL oneshot_busy k=%0d got %b want 1", k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_done k=%0d got %b want 0", k, done); end
      tick();
    end
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL oneshot_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL oneshot_done_pulse got %b want 0", done); end
  endtask

  task automatic test_back_to_back();
    logic exp_led;
    send(32'h3, 6'd2, 1'b0);
    pat_data = 32'h0; pat_len = 6'd2; pat_loop = 1'b0; pat_valid = 1'b1;
    checks++; if (pat_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b got %b want 1", pat_ready); end
    tick();
    pat_data = 32'h1; pat_len = 6'd1; pat_loop = 1'b0;
    for (int k = 1; k < 20; k++) begin
      exp_led = (k < 8) ? 1'b1 : (k < 16) ? 1'b0 : 1'b1;
      checks++; if (led !== exp_led) begin errors++; $display("FAIL b2b_led k=%0d got %b want %b", k, led, exp_led); end
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL b2b_busy_done k=%0d got %b want 10", k, {busy, done}); end
      if (k < 8) begin
        checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall k=%0d ready=%b want 0", k, pat_ready); end
      end
      if (k == 8) begin
        checks++; if (pat_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_c got %b want 1", pat_ready); end
      end
      tick();
      if (k == 8) pat_valid = 1'b0;
    end
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL b2b_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
  endtask

  task automatic test_loop();
    logic exp_led;
    send(32'h1, 6'd2, 1'b1);
    for (int k = 0; k < 40; k++) begin
      exp_led = (k < 32) ? ((k % 8) < 4) : 1'b1;
      checks++; if (led !== exp_led) begin errors++; $display("FAIL loop_led k=%0d got %b want %b", k, led, exp_led); end
      checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL loop_busy_done k=%0d got %b want 10", k, {busy, done}); end
      if (k == 26) begin
        pat_data = 32'h3; pat_len = 6'd2; pat_loop = 1'b0; pat_valid = 1'b1;
        checks++; if (pat_ready !== 1'b1) begin errors++; $display("FAIL loop_ready got %b want 1", pat_ready); end
      end
      tick();
      if (k == 26) pat_valid = 1'b0;
    end
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL loop_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
  endtask

  task automatic test_abort();
    send(32'hF, 6'd4, 1'b0);
    pat_data = 32'h5; pat_len = 6'd4; pat_loop = 1'b1; pat_valid = 1'b1;
    tick();
    pat_valid = 1'b0;
    checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL abort_pend_full ready=%b want 0", pat_ready); end
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    checks++; if ({led, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_out led/busy/done=%b want 000", {led, busy, done}); end
    checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_during got %b want 0", pat_ready); end
    abort = 1'b0;
    #1;
    checks++; if (pat_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after got %b want 1", pat_ready); end
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++; if ({led, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_quiet k=%0d led/busy/done=%b want 000", k, {led, busy, done}); end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_led;
    send(32'hF, 6'd4, 1'b0);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (pat_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", pat_ready); end
    tick();
    checks++; if ({led, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid_out led/busy/done=%b want 000", {led, busy, done}); end
    rst_n = 1'b1;
    tick();
    checks++; if ({led, busy, done} !== 3'b000) begin errors++; $display("FAIL rstmid_idle led/busy/done=%b want 000", {led, busy, done}); end
    send(32'h2, 6'd2, 1'b0);
    for (int k = 0; k < 8; k++) begin
      exp_led = (k >= 4);
      checks++; if ({led, busy} !== {exp_led, 1'b1}) begin errors++; $display("FAIL rstmid_play k=%0d led/busy=%b want %b1", k, {led, busy}, exp_led); end
      tick();
    end
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL rstmid_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
  endtask

  task automatic test_len_clamp();
    logic exp_led;
    send(32'h80000001, 6'd0, 1'b0);
    for (int k = 0; k < 128; k++) begin
      exp_led = (k < 4) || (k >= 124);
      checks++; if ({led, busy, done} !== {exp_led, 2'b10}) begin errors++; $display("FAIL len0 k=%0d led/busy/done=%b want %b10", k, {led, busy, done}, exp_led); end
      tick();
    end
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL len0_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
    // A length above PAT_W also clamps to 32 bits.
    send(32'hFFFFFFFF, 6'd40, 1'b0);
    for (int k = 0; k < 127; k++) tick();
    checks++; if ({led, busy, done} !== 3'b110) begin errors++; $display("FAIL len40_last led/busy/done=%b want 110", {led, busy, done}); end
    tick();
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL len40_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
  endtask

  task automatic test_len_one();
    send(32'h1, 6'd1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checks++; if ({led, busy, done} !== 3'b110) begin errors++; $display("FAIL len1 k=%0d led/busy/done=%b want 110", k, {led, busy, done}); end
      tick();
    end
    checks++; if ({led, busy, done} !== 3'b001) begin errors++; $display("FAIL len1_end led/busy/done=%b want 001", {led, busy, done}); end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; pat_data = '0; pat_len = '0; pat_loop = 1'b0;
    pat_valid = 1'b0; abort = 1'b0;
    test_reset();
    test_one_shot();
    test_back_to_back();
    test_loop();
    test_abort();
    test_reset_mid();
    test_len_clamp();
    test_len_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
